// File: rtl/jelly_unsigned_sqrt_multicycle_ex_pkg.sv
// Shared definitions for the multicycle unsigned square root: FSM encoding
// and derived iteration / counter sizing helpers.
package jelly_unsigned_sqrt_multicycle_ex_pkg;

   localparam logic [1:0] SQRT_IDLE = 2'd0;
   localparam logic [1:0] SQRT_CALC = 2'd1;
   localparam logic [1:0] SQRT_FIX  = 2'd2;
   localparam logic [1:0] SQRT_DONE = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = SQRT_IDLE,
      ST_CALC = SQRT_CALC,
      ST_FIX  = SQRT_FIX,
      ST_DONE = SQRT_DONE
   } sqrt_state_t;

   // Number of CALC cycles needed to resolve every root bit.
   function automatic int sqrt_iterations(input int data_width, input int steps_per_cycle);
      return data_width / steps_per_cycle;
   endfunction

   // Counter must hold ITERATIONS-1; keep at least one bit when a single cycle suffices.
   function automatic int sqrt_cnt_width(input int iterations);
      return (iterations > 1) ? $clog2(iterations) : 1;
   endfunction

endpackage

// File: rtl/jelly_unsigned_sqrt_step.sv
// One combinational restoring square-root step: appends two radicand bits to
// the partial remainder, trial-subtracts {root,01} and shifts one root bit in.
module jelly_unsigned_sqrt_step #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH:0]   rem_i,
   input  logic [DATA_WIDTH-1:0] root_i,
   input  logic [1:0]            bits_i,
   output logic [DATA_WIDTH:0]   rem_o,
   output logic [DATA_WIDTH-1:0] root_o
);

   logic [DATA_WIDTH+2:0] cat;
   logic [DATA_WIDTH+1:0] sub;
   logic [DATA_WIDTH:0]   diff;
   logic                  ge;

   assign cat = {rem_i, bits_i};
   assign sub = {root_i, 2'b01};
   assign ge  = (cat >= {1'b0, sub});

   // The kept remainder never exceeds 2*root, so the low DATA_WIDTH+1 bits
   // of the modular difference are exact whenever the trial succeeds.
   assign diff = cat[DATA_WIDTH:0] - sub[DATA_WIDTH:0];

   assign rem_o  = ge ? diff : cat[DATA_WIDTH:0];
   assign root_o = {root_i[DATA_WIDTH-2:0], ge};

endmodule

// File: rtl/jelly_unsigned_sqrt_multicycle_ex.sv
// Iterative unsigned square root of a 2*DATA_WIDTH radicand, STEPS_PER_CYCLE
// root bits per clock, with optional round-to-nearest and a user sideband.
module jelly_unsigned_sqrt_multicycle_ex
   import jelly_unsigned_sqrt_multicycle_ex_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int STEPS_PER_CYCLE = 1,
   parameter int USER_WIDTH      = 0,
   localparam int USER_BITS      = (USER_WIDTH > 0) ? USER_WIDTH : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cke,

   input  logic [2*DATA_WIDTH-1:0] s_data,
   input  logic                    s_round,
   input  logic [USER_BITS-1:0]    s_user,
   input  logic                    s_valid,
   output logic                    s_ready,

   output logic [DATA_WIDTH-1:0]   m_data,
   output logic [DATA_WIDTH:0]     m_remainder,
   output logic                    m_saturated,
   output logic [USER_BITS-1:0]    m_user,
   output logic                    m_valid,
   input  logic                    m_ready
);

   localparam int ITER  = sqrt_iterations(DATA_WIDTH, STEPS_PER_CYCLE);
   localparam int CNT_W = sqrt_cnt_width(ITER);
   localparam int XW    = 2 * DATA_WIDTH;

   if ((DATA_WIDTH % STEPS_PER_CYCLE) != 0) begin : g_bad_steps
      $error("STEPS_PER_CYCLE must divide DATA_WIDTH exactly");
   end

   sqrt_state_t           state_q;
   logic                  ready_q;
   logic [XW-1:0]         x_q, x_d;
   logic [DATA_WIDTH:0]   rem_q, rem_d;
   logic [DATA_WIDTH-1:0] root_q, root_d;
   logic [CNT_W-1:0]      cnt_q;
   logic                  round_q;
   logic [USER_BITS-1:0]  user_q;

   logic [DATA_WIDTH-1:0] m_data_q;
   logic [DATA_WIDTH:0]   m_remainder_q;
   logic                  m_saturated_q;
   logic [USER_BITS-1:0]  m_user_q;
   logic                  m_valid_q;

   logic                  accept;

   // Unrolled chain of restoring steps resolved in one clock
   logic [DATA_WIDTH:0]   rem_c  [0:STEPS_PER_CYCLE];
   logic [DATA_WIDTH-1:0] root_c [0:STEPS_PER_CYCLE];

   assign rem_c[0]  = rem_q;
   assign root_c[0] = root_q;

   for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
      jelly_unsigned_sqrt_step #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_step (
         .rem_i  (rem_c[i]),
         .root_i (root_c[i]),
         .bits_i (x_q[XW-1-2*i -: 2]),
         .rem_o  (rem_c[i+1]),
         .root_o (root_c[i+1])
      );
   end

   assign rem_d  = rem_c[STEPS_PER_CYCLE];
   assign root_d = root_c[STEPS_PER_CYCLE];
   assign x_d    = x_q << (2 * STEPS_PER_CYCLE);

   // Rounding: round up when x >= (q + 0.5)^2, i.e. remainder > q.
   logic [DATA_WIDTH:0]   root_inc;
   logic                  round_up;
   logic                  sat_fix;
   logic [DATA_WIDTH-1:0] data_fix;

   assign root_inc = {1'b0, root_q} + {{DATA_WIDTH{1'b0}}, 1'b1};
   assign round_up = round_q && (rem_q > {1'b0, root_q});
   assign sat_fix  = round_up && root_inc[DATA_WIDTH];
   assign data_fix = sat_fix  ? {DATA_WIDTH{1'b1}} :
                     round_up ? root_inc[DATA_WIDTH-1:0] : root_q;

   // While holding a result, ready follows m_ready so a new operand can be
   // taken in the same cycle the old result leaves.
   assign s_ready = (state_q == ST_DONE) ? m_ready : ready_q;
   assign accept  = s_valid && s_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         ready_q       <= 1'b0;
         x_q           <= '0;
         rem_q         <= '0;
         root_q        <= '0;
         cnt_q         <= '0;
         round_q       <= 1'b0;
         user_q        <= '0;
         m_data_q      <= '0;
         m_remainder_q <= '0;
         m_saturated_q <= 1'b0;
         m_user_q      <= '0;
         m_valid_q     <= 1'b0;
      end else if (cke) begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  ready_q <= 1'b0;
                  state_q <= ST_CALC;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            ST_CALC: begin
               x_q    <= x_d;
               rem_q  <= rem_d;
               root_q <= root_d;
               cnt_q  <= cnt_q - CNT_W'(1);
               if (cnt_q == '0) begin
                  state_q <= ST_FIX;
               end
            end
            ST_FIX: begin
               m_data_q      <= data_fix;
               m_remainder_q <= rem_q;
               m_saturated_q <= sat_fix;
               m_user_q      <= user_q;
               m_valid_q     <= 1'b1;
               state_q       <= ST_DONE;
            end
            ST_DONE: begin
               if (m_valid_q && m_ready) begin
                  m_valid_q <= 1'b0;
                  if (accept) begin
                     ready_q <= 1'b0;
                     state_q <= ST_CALC;
                  end else begin
                     ready_q <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b0;
            end
         endcase

         // Operand capture; s_ready is low in CALC/FIX so this never
         // collides with the iteration updates above.
         if (accept) begin
            x_q     <= s_data;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= CNT_W'(ITER - 1);
            round_q <= s_round;
            user_q  <= s_user;
         end
      end
   end

   assign m_data      = m_data_q;
   assign m_remainder = m_remainder_q;
   assign m_saturated = m_saturated_q;
   assign m_user      = m_user_q;
   assign m_valid     = m_valid_q;

endmodule

// File: tb/tb_jelly_unsigned_sqrt_multicycle_ex.sv
// Directed bench: 8-bit root with 1 step/cycle (user sideband) and 4 steps/cycle (no sideband).
module tb_jelly_unsigned_sqrt_multicycle_ex;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic cke = 1'b1;

   logic [15:0] s_data1 = '0;
   logic        s_round1 = 1'b0;
   logic [7:0]  s_user1 = '0;
   logic        s_valid1 = 1'b0;
   logic        s_ready1;
   logic [7:0]  m_data1;
   logic [8:0]  m_rem1;
   logic        m_sat1;
   logic [7:0]  m_user1;
   logic        m_valid1;
   logic        m_ready1 = 1'b0;

   logic [15:0] s_data4 = '0;
   logic        s_round4 = 1'b0;
   logic [0:0]  s_user4 = '0;
   logic        s_valid4 = 1'b0;
   logic        s_ready4;
   logic [7:0]  m_data4;
   logic [8:0]  m_rem4;
   logic        m_sat4;
   logic [0:0]  m_user4;
   logic        m_valid4;
   logic        m_ready4 = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   jelly_unsigned_sqrt_multicycle_ex #(
      .DATA_WIDTH (8), .STEPS_PER_CYCLE (1), .USER_WIDTH (8)
   ) dut1 (
      .clk (clk), .reset (reset), .cke (cke),
      .s_data (s_data1), .s_round (s_round1), .s_user (s_user1),
      .s_valid (s_valid1), .s_ready (s_ready1),
      .m_data (m_data1), .m_remainder (m_rem1), .m_saturated (m_sat1),
      .m_user (m_user1), .m_valid (m_valid1), .m_ready (m_ready1)
   );

   jelly_unsigned_sqrt_multicycle_ex #(
      .DATA_WIDTH (8), .STEPS_PER_CYCLE (4), .USER_WIDTH (0)
   ) dut4 (
      .clk (clk), .reset (reset), .cke (cke),
      .s_data (s_data4), .s_round (s_round4), .s_user (s_user4),
      .s_valid (s_valid4), .s_ready (s_ready4),
      .m_data (m_data4), .m_remainder (m_rem4), .m_saturated (m_sat4),
      .m_user (m_user4), .m_valid (m_valid4), .m_ready (m_ready4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one operand to dut1 and counts edges from accept to m_valid.
   task automatic run_op1(input logic [15:0] d, input logic rnd, input logic [7:0] u,
                          output int lat, output bit to);
      int w;
      to = 1'b0;
      w = 0;
      while (!s_ready1 && w < 40) begin tick(); w++; end
      if (!s_ready1) to = 1'b1;
      s_data1 = d; s_round1 = rnd; s_user1 = u; s_valid1 = 1'b1;
      tick();
      s_valid1 = 1'b0;
      lat = 0;
      while (!m_valid1 && lat < 60) begin tick(); lat++; end
      if (!m_valid1) to = 1'b1;
   endtask

   task automatic release1();
      m_ready1 = 1'b1;
      tick();
      m_ready1 = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      n_cmp++; if (m_valid1 !== 1'b0) begin n_err++; $display("FAIL rst_m_valid: got %0b want 0", m_valid1); end
      n_cmp++; if (s_ready1 !== 1'b0) begin n_err++; $display("FAIL rst_s_ready: got %0b want 0", s_ready1); end
      n_cmp++; if (m_data1 !== 8'd0) begin n_err++; $display("FAIL rst_m_data: got %0d want 0", m_data1); end
      n_cmp++; if (m_rem1 !== 9'd0) begin n_err++; $display("FAIL rst_m_rem: got %0d want 0", m_rem1); end
      n_cmp++; if (m_sat1 !== 1'b0) begin n_err++; $display("FAIL rst_m_sat: got %0b want 0", m_sat1); end
      n_cmp++; if (m_user1 !== 8'd0) begin n_err++; $display("FAIL rst_m_user: got %0h want 0", m_user1); end
      reset = 1'b0;
      tick();
      n_cmp++; if (s_ready1 !== 1'b1) begin n_err++; $display("FAIL rst_ready_after1: got %0b want 1", s_ready1); end
      n_cmp++; if (s_ready4 !== 1'b1) begin n_err++; $display("FAIL rst_ready_after4: got %0b want 1", s_ready4); end
   endtask

   task automatic test_truncate();
      int lat; bit to;
      run_op1(16'd200, 1'b0, 8'h33, lat, to);
      n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL trunc200_timeout: got %0b want 0", to); end
      n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL trunc200_latency: got %0d want 9", lat); end
      n_cmp++; if (m_data1 !== 8'd14) begin n_err++; $display("FAIL trunc200_data: got %0d want 14", m_data1); end
      n_cmp++; if (m_rem1 !== 9'd4) begin n_err++; $display("FAIL trunc200_rem: got %0d want 4", m_rem1); end
      n_cmp++; if (m_sat1 !== 1'b0) begin n_err++; $display("FAIL trunc200_sat: got %0b want 0", m_sat1); end
      n_cmp++; if (m_user1 !== 8'h33) begin n_err++; $display("FAIL trunc200_user: got %0h want 33", m_user1); end
      release1();
      n_cmp++; if (m_valid1 !== 1'b0) begin n_err++; $display("FAIL trunc200_drop: got %0b want 0", m_valid1); end
      run_op1(16'd0, 1'b1, 8'h01, lat, to);
      n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL zero_timeout: got %0b want 0", to); end
      n_cmp++; if (m_data1 !== 8'd0) begin n_err++; $display("FAIL zero_data: got %0d want 0", m_data1); end
      n_cmp++; if (m_rem1 !== 9'd0) begin n_err++; $display("FAIL zero_rem: got %0d want 0", m_rem1); end
      n_cmp++; if (m_sat1 !== 1'b0) begin n_err++; $display("FAIL zero_sat: got %0b want 0", m_sat1); end
      release1();
   endtask

   task automatic test_round();
      int lat; bit to;
      run_op1(16'd210, 1'b1, 8'h02, lat, to);
      n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL rnd210_timeout: got %0b want 0", to); end
      n_cmp++; if (m_data1 !== 8'd14) begin n_err++; $display("FAIL rnd210_data: got %0d want 14", m_data1); end
      n_cmp++; if (m_rem1 !== 9'd14) begin n_err++; $display("FAIL rnd210_rem: got %0d want 14", m_rem1); end
      release1();
      run_op1(16'd211, 1'b1, 8'h03, lat, to);
      n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL rnd211_timeout: got %0b want 0", to); end
      n_cmp++; if (m_data1 !== 8'd15) begin n_err++; $display("FAIL rnd211_data: got %0d want 15", m_data1); end
      n_cmp++; if (m_rem1 !== 9'd15) begin n_err++; $display("FAIL rnd211_rem: got %0d want 15", m_rem1); end
      n_cmp++; if (m_sat1 !== 1'b0) begin n_err++; $display("FAIL rnd211_sat: got %0b want 0", m_sat1); end
      release1();
   endtask

   task automatic test_saturate();
      int lat; bit to;
      run_op1(16'hFFFF, 1'b1, 8'h04, lat, to);
      n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL sat_r1_timeout: got %0b want 0", to); end
      n_cmp++; if (m_data1 !== 8'd255) begin n_err++; $display("FAIL sat_r1_data: got %0d want 255", m_data1); end
      n_cmp++; if (m_rem1 !== 9'd510) begin n_err++; $display("FAIL sat_r1_rem: got %0d want 510", m_rem1); end
      n_cmp++; if (m_sat1 !== 1'b1) begin n_err++; $display("FAIL sat_r1_flag: got %0b want 1", m_sat1); end
      release1();
      run_op1(16'hFFFF, 1'b0, 8'h05, lat, to);
      n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL sat_r0_timeout: got %0b want 0", to); end
      n_cmp++; if (m_data1 !== 8'd255) begin n_err++; $display("FAIL sat_r0_data: got %0d want 255", m_data1); end
      n_cmp++; if (m_rem1 !== 9'd510) begin n_err++; $display("FAIL sat_r0_rem: got %0d want 510", m_rem1); end
      n_cmp++; if (m_sat1 !== 1'b0) begin n_err++; $display("FAIL sat_r0_flag: got %0b want 0", m_sat1); end
      release1();
   endtask

   task automatic test_back_to_back();
      int lat; int w;
      m_ready4 = 1'b1;
      w = 0;
      while (!s_ready4 && w < 40) begin tick(); w++; end
      n_cmp++; if (s_ready4 !== 1'b1) begin n_err++; $display("FAIL b2b_ready0: got %0b want 1", s_ready4); end
      s_data4 = 16'd0; s_valid4 = 1'b1;
      tick();
      s_data4 = 16'd65025;
      lat = 0;
      while (!m_valid4 && lat < 30) begin tick(); lat++; end
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL b2b_lat1: got %0d want 3", lat); end
      n_cmp++; if (m_data4 !== 8'd0) begin n_err++; $display("FAIL b2b_data1: got %0d want 0", m_data4); end
      n_cmp++; if (m_rem4 !== 9'd0) begin n_err++; $display("FAIL b2b_rem1: got %0d want 0", m_rem4); end
      n_cmp++; if (s_ready4 !== 1'b1) begin n_err++; $display("FAIL b2b_ready_done: got %0b want 1", s_ready4); end
      tick();
      s_valid4 = 1'b0;
      n_cmp++; if (m_valid4 !== 1'b0) begin n_err++; $display("FAIL b2b_handshake: got %0b want 0", m_valid4); end
      n_cmp++; if (s_ready4 !== 1'b0) begin n_err++; $display("FAIL b2b_busy: got %0b want 0", s_ready4); end
      lat = 0;
      while (!m_valid4 && lat < 30) begin tick(); lat++; end
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL b2b_lat2: got %0d want 3", lat); end
      n_cmp++; if (m_data4 !== 8'd255) begin n_err++; $display("FAIL b2b_data2: got %0d want 255", m_data4); end
      n_cmp++; if (m_rem4 !== 9'd0) begin n_err++; $display("FAIL b2b_rem2: got %0d want 0", m_rem4); end
      n_cmp++; if (m_sat4 !== 1'b0) begin n_err++; $display("FAIL b2b_sat2: got %0b want 0", m_sat4); end
      tick();
      m_ready4 = 1'b0;
      n_cmp++; if (m_valid4 !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %0b want 0", m_valid4); end
   endtask

   task automatic test_backpressure();
      int w;
      w = 0;
      while (!s_ready1 && w < 40) begin tick(); w++; end
      s_data1 = 16'd200; s_round1 = 1'b0; s_user1 = 8'h5A; s_valid1 = 1'b1;
      cke = 1'b1;
      tick();
      s_valid1 = 1'b0;
      w = 0;
      while (!m_valid1 && w < 200) begin cke = 1'($urandom_range(0, 1)); tick(); w++; end
      n_cmp++; if (m_valid1 !== 1'b1) begin n_err++; $display("FAIL bp_valid_timeout: got %0b want 1", m_valid1); end
      for (int k = 0; k < 10; k++) begin
         cke = 1'($urandom_range(0, 1));
         tick();
         n_cmp++; if (m_valid1 !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d]: got %0b want 1", k, m_valid1); end
         n_cmp++; if (m_data1 !== 8'd14) begin n_err++; $display("FAIL bp_hold_data[%0d]: got %0d want 14", k, m_data1); end
         n_cmp++; if (m_rem1 !== 9'd4) begin n_err++; $display("FAIL bp_hold_rem[%0d]: got %0d want 4", k, m_rem1); end
         n_cmp++; if (m_user1 !== 8'h5A) begin n_err++; $display("FAIL bp_hold_user[%0d]: got %0h want 5a", k, m_user1); end
         n_cmp++; if (s_ready1 !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready[%0d]: got %0b want 0", k, s_ready1); end
      end
      cke = 1'b1;
      m_ready1 = 1'b1;
      #1;
      n_cmp++; if (s_ready1 !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %0b want 1", s_ready1); end
      tick();
      m_ready1 = 1'b0;
      n_cmp++; if (m_valid1 !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %0b want 0", m_valid1); end
   endtask

   task automatic test_reset_mid();
      int lat; bit to; int w;
      w = 0;
      while (!s_ready1 && w < 40) begin tick(); w++; end
      s_data1 = 16'hFFFF; s_round1 = 1'b1; s_user1 = 8'h11; s_valid1 = 1'b1;
      tick();
      s_valid1 = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      n_cmp++; if (m_valid1 !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %0b want 0", m_valid1); end
      n_cmp++; if (s_ready1 !== 1'b0) begin n_err++; $display("FAIL midrst_ready: got %0b want 0", s_ready1); end
      reset = 1'b0;
      run_op1(16'd200, 1'b1, 8'h22, lat, to);
      n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL midrst_timeout: got %0b want 0", to); end
      n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL midrst_latency: got %0d want 9", lat); end
      n_cmp++; if (m_data1 !== 8'd14) begin n_err++; $display("FAIL midrst_data: got %0d want 14", m_data1); end
      n_cmp++; if (m_rem1 !== 9'd4) begin n_err++; $display("FAIL midrst_rem: got %0d want 4", m_rem1); end
      n_cmp++; if (m_sat1 !== 1'b0) begin n_err++; $display("FAIL midrst_sat: got %0b want 0", m_sat1); end
      n_cmp++; if (m_user1 !== 8'h22) begin n_err++; $display("FAIL midrst_user: got %0h want 22", m_user1); end
      release1();
   endtask

   initial begin
      test_reset();
      test_truncate();
      test_round();
      test_saturate();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
